// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI peripherals.
package idli_pkg;

   typedef logic [3:0] sqi_data_t;

   localparam logic [7:0] SQI_CMD_READ      = 8'h03;
   localparam logic [7:0] SQI_CMD_WRITE     = 8'h02;
   localparam int         SQI_ADDR_NIBBLES  = 6;
   localparam int         SQI_DUMMY_NIBBLES = 2;

   typedef enum logic [2:0] {
      SQI_MEM_IDLE,
      SQI_MEM_CMD,
      SQI_MEM_ADDR,
      SQI_MEM_DUMMY,
      SQI_MEM_RDATA,
      SQI_MEM_WDATA,
      SQI_MEM_ERR
   } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_if.sv
// SQI lane between the core's initiator (master) and one memory responder (slave).
interface idli_sqi_mem_if;
   import idli_pkg::*;

   logic      i_mem_sck;
   logic      i_mem_cs;
   sqi_data_t i_mem_sio;
   sqi_data_t o_mem_sio;
   logic      o_mem_sio_oe;

   modport master (
      output i_mem_sck, i_mem_cs, i_mem_sio,
      input  o_mem_sio, o_mem_sio_oe
   );

   modport slave (
      input  i_mem_sck, i_mem_cs, i_mem_sio,
      output o_mem_sio, o_mem_sio_oe
   );
endinterface

// File: rtl/idli_sqi_mem_ram_m.sv
// DEPTH x 8 byte store: one synchronous write port, one asynchronous read port.
// Contents are not reset; FPGA builds may substitute a vendor block RAM here.
module idli_sqi_mem_ram_m #(
   parameter int DEPTH  = 131072,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdat,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdat
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdat;
   end

   assign rdat = mem[raddr];
endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes READ/WRITE frames, samples SIO on SCK rise, drives on fall.
// Read data appears on the fall after the last dummy rise; no backpressure, the initiator paces via SCK.
module idli_sqi_mem_m
   import idli_pkg::*;
#(
   parameter int DEPTH  = 131072,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic          i_mem_gck,
   input  logic          i_mem_rst,
   idli_sqi_mem_if.slave mem
);
   sqi_mem_state_t    state;
   logic              sck_q;
   logic              cs_q;
   logic              cs_seen;
   logic [2:0]        cnt;
   logic              nib_lo;
   logic [7:0]        cmd;
   logic [ADDR_W-1:0] addr;
   sqi_data_t         wr_hi;
   sqi_data_t         sio_q;
   logic              oe_q;
   logic [7:0]        rd_dat;

   logic       rise, fall, cs_start, wr_en;
   logic [7:0] cmd_nxt;

   assign rise    = mem.i_mem_sck & ~sck_q;
   assign fall    = ~mem.i_mem_sck & sck_q;
   // cs_q resets high, so cs_seen stops a CS already low at reset release from looking like a new frame.
   assign cs_start = ~mem.i_mem_cs & cs_q & cs_seen;
   assign cmd_nxt  = {cmd[3:0], mem.i_mem_sio};
   assign wr_en    = (state == SQI_MEM_WDATA) & rise & nib_lo & ~mem.i_mem_cs;

   always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
      if (i_mem_rst) begin
         state   <= SQI_MEM_IDLE;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         cs_seen <= 1'b0;
         cnt     <= 3'd0;
         nib_lo  <= 1'b0;
         cmd     <= 8'h00;
         addr    <= '0;
         wr_hi   <= 4'h0;
         sio_q   <= 4'h0;
         oe_q    <= 1'b0;
      end else begin
         sck_q <= mem.i_mem_sck;
         cs_q  <= mem.i_mem_cs;
         if (mem.i_mem_cs) cs_seen <= 1'b1;

         if (mem.i_mem_cs) begin
            state <= SQI_MEM_IDLE;
            oe_q  <= 1'b0;
         end else begin
            case (state)
               SQI_MEM_IDLE: if (cs_start) begin
                  state  <= SQI_MEM_CMD;
                  cnt    <= 3'd0;
                  nib_lo <= 1'b0;
               end
               SQI_MEM_CMD: if (rise) begin
                  cmd <= cmd_nxt;
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd1) begin
                     cnt   <= 3'd0;
                     state <= (cmd_nxt == SQI_CMD_READ || cmd_nxt == SQI_CMD_WRITE)
                              ? SQI_MEM_ADDR : SQI_MEM_ERR;
                  end
               end
               SQI_MEM_ADDR: if (rise) begin
                  addr <= ADDR_W'({addr, mem.i_mem_sio});
                  cnt  <= cnt + 3'd1;
                  if (cnt == 3'(SQI_ADDR_NIBBLES - 1)) begin
                     cnt    <= 3'd0;
                     nib_lo <= 1'b0;
                     state  <= (cmd == SQI_CMD_READ) ? SQI_MEM_DUMMY : SQI_MEM_WDATA;
                  end
               end
               SQI_MEM_DUMMY: if (rise) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'(SQI_DUMMY_NIBBLES - 1)) begin
                     cnt   <= 3'd0;
                     state <= SQI_MEM_RDATA;
                  end
               end
               SQI_MEM_RDATA: if (fall) begin
                  oe_q   <= 1'b1;
                  nib_lo <= ~nib_lo;
                  sio_q  <= nib_lo ? rd_dat[3:0] : rd_dat[7:4];
                  if (nib_lo) addr <= addr + 1'b1;
               end
               SQI_MEM_WDATA: if (rise) begin
                  nib_lo <= ~nib_lo;
                  if (!nib_lo) wr_hi <= mem.i_mem_sio;
                  else         addr  <= addr + 1'b1;
               end
               SQI_MEM_ERR: ;
               default: state <= SQI_MEM_IDLE;
            endcase
         end
      end
   end

   idli_sqi_mem_ram_m #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (i_mem_gck),
      .we    (wr_en),
      .waddr (addr),
      .wdat  ({wr_hi, mem.i_mem_sio}),
      .raddr (addr),
      .rdat  (rd_dat)
   );

   assign mem.o_mem_sio    = sio_q;
   assign mem.o_mem_sio_oe = oe_q;
endmodule
